// File: rtl/smpl_ram_dump.sv
// smpl_ram_dump: reads the circular capture RAM starting at the oldest word,
// unpacks each word into samples (first-captured sample in the MS slot) and
// hands them one at a time to the UART transmitter.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   dump         one-cycle start pulse (ignored while busy)
//   start_addr   oldest word address, must be < DEPTH
//   ren, raddr   RAM read port request (data returns one cycle later)
//   rdata        RAM read data
//   tx_data      sample byte presented to the UART
//   trmt         one-cycle transmit request
//   tx_done      UART byte-complete pulse
//   busy         high while a dump is in progress
//   done         one-cycle pulse after the final byte completes
module smpl_ram_dump #(
   parameter int unsigned ADDR_W        = 9,
   parameter int unsigned DEPTH         = 384,
   parameter int unsigned SMPL_W        = 8,
   parameter int unsigned SMPL_PER_WORD = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            dump,
   input  logic [ADDR_W-1:0]               start_addr,
   output logic                            ren,
   output logic [ADDR_W-1:0]               raddr,
   input  logic [SMPL_W*SMPL_PER_WORD-1:0] rdata,
   output logic [SMPL_W-1:0]               tx_data,
   output logic                            trmt,
   input  logic                            tx_done,
   output logic                            busy,
   output logic                            done
);

   localparam int unsigned WORD_W = SMPL_W * SMPL_PER_WORD;
   localparam int unsigned SLOT_W = (SMPL_PER_WORD > 1) ? $clog2(SMPL_PER_WORD) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SMPL_PER_WORD - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_SEND,
      S_WAIT,
      S_FIN
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   raddr_q, raddr_d;
   logic [ADDR_W-1:0]   cnt_q,   cnt_d;
   logic [SLOT_W-1:0]   slot_q,  slot_d;
   logic [WORD_W-1:0]   word_q,  word_d;
   logic [SMPL_W-1:0]   tx_data_q, tx_data_d;
   logic                ren_q,  ren_d;
   logic                trmt_q, trmt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Select a sample slot from a packed word; slot 0 is the most-significant sample.
   function automatic logic [SMPL_W-1:0] pick(input logic [WORD_W-1:0] w,
                                              input logic [SLOT_W-1:0] s);
      logic [SMPL_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < SMPL_PER_WORD; i++) begin
         if (s == SLOT_W'(i)) r = w[(SMPL_PER_WORD-1-i)*SMPL_W +: SMPL_W];
      end
      return r;
   endfunction

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         raddr_q   <= '0;
         cnt_q     <= '0;
         slot_q    <= '0;
         word_q    <= '0;
         tx_data_q <= '0;
         ren_q     <= 1'b0;
         trmt_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         raddr_q   <= raddr_d;
         cnt_q     <= cnt_d;
         slot_q    <= slot_d;
         word_q    <= word_d;
         tx_data_q <= tx_data_d;
         ren_q     <= ren_d;
         trmt_q    <= trmt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic; pulse outputs are set on the transition into the state
   // that owns them so they appear registered during that state.
   always_comb begin
      state_d   = state_q;
      raddr_d   = raddr_q;
      cnt_d     = cnt_q;
      slot_d    = slot_q;
      word_d    = word_q;
      tx_data_d = tx_data_q;
      ren_d     = 1'b0;
      trmt_d    = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (dump) begin
               raddr_d = start_addr;
               cnt_d   = '0;
               busy_d  = 1'b1;
               ren_d   = 1'b1;
               state_d = S_RD;
            end
         end
         S_RD: begin
            state_d = S_CAP;
         end
         S_CAP: begin
            // rdata is valid now (one-cycle read latency); slot 0 goes out directly.
            word_d    = rdata;
            slot_d    = '0;
            tx_data_d = pick(rdata, '0);
            trmt_d    = 1'b1;
            state_d   = S_SEND;
         end
         S_SEND: begin
            // tx_done coinciding with trmt is deliberately not honoured here.
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               if (slot_q != LAST_SLOT) begin
                  slot_d    = slot_q + SLOT_W'(1);
                  tx_data_d = pick(word_q, slot_q + SLOT_W'(1));
                  trmt_d    = 1'b1;
                  state_d   = S_SEND;
               end else if (cnt_q == LAST_ADDR) begin
                  done_d  = 1'b1;
                  state_d = S_FIN;
               end else begin
                  // Circular buffer wraps at DEPTH, not at the address-space size.
                  cnt_d   = cnt_q + ADDR_W'(1);
                  raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + ADDR_W'(1);
                  ren_d   = 1'b1;
                  state_d = S_RD;
               end
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ren     = ren_q;
   assign raddr   = raddr_q;
   assign tx_data = tx_data_q;
   assign trmt    = trmt_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_smpl_ram_dump.sv
module tb_smpl_ram_dump;

   localparam int ADDR_W = 9;
   localparam int DEPTH  = 384;
   localparam int SMPL_W = 8;
   localparam int SPW    = 4;
   localparam int WORD_W = SMPL_W * SPW;

   logic                clk = 1'b0;
   logic                rst_n, dump, ren, trmt, tx_done, busy, done;
   logic [ADDR_W-1:0]   start_addr, raddr;
   logic [WORD_W-1:0]   rdata;
   logic [SMPL_W-1:0]   tx_data;

   always #5 clk = ~clk;

   smpl_ram_dump #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SMPL_W(SMPL_W), .SMPL_PER_WORD(SPW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .dump(dump), .start_addr(start_addr),
      .ren(ren), .raddr(raddr), .rdata(rdata), .tx_data(tx_data),
      .trmt(trmt), .tx_done(tx_done), .busy(busy), .done(done)
   );

   // RAM model with one-cycle read latency.
   logic [WORD_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ren) begin
         if (int'(raddr) < DEPTH) rdata <= mem[raddr];
         else                     rdata <= 'x;
      end
   end

   // UART responder: tx_done resp_delay cycles after each trmt; optional stray
   // tx_done pulses in RD, CAP and SEND cycles.
   int resp_delay = 1;
   bit stray      = 1'b0;
   initial begin
      int ctr;
      bit pend;
      bit pren;
      tx_done = 1'b0; pend = 1'b0; pren = 1'b0; ctr = 0;
      forever begin
         @(posedge clk); #1;
         tx_done = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               ctr--;
               if (ctr == 0) begin tx_done = 1'b1; pend = 1'b0; end
            end
            if (trmt) begin pend = 1'b1; ctr = resp_delay; end
            if (stray && (ren || pren || trmt)) tx_done = 1'b1;
         end
         pren = ren;
      end
   end

   // Monitor: collects bytes and read addresses, checks tx_data holds while waiting.
   logic [7:0] byte_q [$];
   int         addr_q [$];
   int         mon_done = 0, stab_err = 0, oob = 0;
   bit         hold = 1'b0;
   logic [7:0] hold_v;
   always @(negedge clk) begin
      if (!rst_n || !busy) hold = 1'b0;
      if (ren) begin
         addr_q.push_back(int'(raddr));
         if (int'(raddr) >= DEPTH) oob++;
      end
      if (done) mon_done++;
      if (trmt) begin
         byte_q.push_back(tx_data);
         hold = 1'b1; hold_v = tx_data;
      end else if (hold) begin
         if (tx_data !== hold_v) stab_err++;
         if (tx_done) hold = 1'b0;
      end
   end

   int total = 0, bad = 0;
   int b_byte, b_addr, b_done, b_stab, b_oob;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mark();
      b_byte = byte_q.size(); b_addr = addr_q.size();
      b_done = mon_done; b_stab = stab_err; b_oob = oob;
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < DEPTH; i++) begin
         logic [7:0] b;
         b = 8'(i);
         mem[i] = {b, 8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3)};
      end
   endtask

   // Reference: k-th byte of a dump from start is slot k%SPW of word (start+k/SPW) mod DEPTH.
   function automatic int exp_byte(input int start, input int k);
      int a;
      logic [WORD_W-1:0] w;
      a = (start + k / SPW) % DEPTH;
      w = mem[a];
      return int'(8'(w >> (8 * (SPW - 1 - (k % SPW)))));
   endfunction

   function automatic int max_cyc();
      return DEPTH * SPW * (resp_delay + 2) + DEPTH * 4 + 100;
   endfunction

   task automatic start_dump(input int start);
      @(negedge clk);
      mark();
      start_addr = ADDR_W'(start);
      dump = 1'b1;
      @(negedge clk);
      dump = 1'b0;
   endtask

   // Wait for done (returns at the negedge of the done cycle); optionally
   // pulse dump while busy once word 10 has been read.
   task automatic finish_wait(input string tag, input bit inj);
      bit ok, injd;
      int lim;
      ok = 1'b0; injd = 1'b0; lim = max_cyc();
      for (int c = 0; c < lim; c++) begin
         @(negedge clk);
         dump = 1'b0;
         if (done) begin ok = 1'b1; break; end
         if (inj && !injd && (addr_q.size() - b_addr) == 11) begin
            dump = 1'b1; injd = 1'b1;
         end
      end
      chk({tag, " done_seen"}, int'(ok), 1);
   endtask

   task automatic check_dump(input string tag, input int start);
      int nb, na, em, am;
      nb = byte_q.size() - b_byte;
      na = addr_q.size() - b_addr;
      chk({tag, " nbytes"}, nb, DEPTH * SPW);
      chk({tag, " nren"}, na, DEPTH);
      em = 0;
      for (int k = 0; k < nb && k < DEPTH * SPW; k++)
         if (int'(byte_q[b_byte + k]) !== exp_byte(start, k)) em++;
      chk({tag, " byte_seq_errs"}, em, 0);
      am = 0;
      for (int k = 0; k < na && k < DEPTH; k++)
         if (addr_q[b_addr + k] != (start + k) % DEPTH) am++;
      chk({tag, " addr_seq_errs"}, am, 0);
      chk({tag, " ndone"}, mon_done - b_done, 1);
      chk({tag, " raddr_oob"}, oob - b_oob, 0);
      chk({tag, " tx_data_unstable"}, stab_err - b_stab, 0);
   endtask

   function automatic int outs();
      return int'({ren, raddr, tx_data, trmt, busy, done});
   endfunction

   typedef struct {
      int start;
      int delay;
      bit stray;
      bit inject;
      int first_b;
      int last_b;
   } vec_t;

   initial begin
      vec_t tv [4];
      int   gap, s1, s2, nb;
      bit   found;

      tv[0] = '{start: 5,   delay: 2, stray: 1'b0, inject: 1'b0, first_b: 'h05, last_b: 'h07};
      tv[1] = '{start: 0,   delay: 5, stray: 1'b0, inject: 1'b0, first_b: 'h00, last_b: 'h82};
      tv[2] = '{start: 383, delay: 1, stray: 1'b0, inject: 1'b0, first_b: 'h7F, last_b: 'h81};
      tv[3] = '{start: 200, delay: 1, stray: 1'b1, inject: 1'b1, first_b: 'hC8, last_b: 'hCA};

      rst_n = 1'b0; dump = 1'b0; start_addr = '0;
      fill_pattern();
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      // Latency and hold: ren at +1, trmt at +3, tx_data held through a 1000-cycle wait.
      resp_delay = 1000; stray = 1'b0;
      @(negedge clk);
      mark();
      start_addr = ADDR_W'(7); dump = 1'b1;
      @(negedge clk); dump = 1'b0;
      chk("t_ren_p1", int'(ren), 1);
      chk("t_raddr_p1", int'(raddr), 7);
      chk("t_busy_p1", int'(busy), 1);
      @(negedge clk);
      chk("t_ren_p2", int'(ren), 0);
      chk("t_trmt_p2", int'(trmt), 0);
      @(negedge clk);
      chk("t_trmt_p3", int'(trmt), 1);
      chk("t_txd0", int'(tx_data), 'h07);
      gap = 0;
      do begin @(negedge clk); gap++; end while (!trmt && gap < 1100);
      chk("t_gap", gap, 1001);
      chk("t_txd1", int'(tx_data), 'h08);
      chk("t_stable", stab_err - b_stab, 0);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Reset during WAIT on word 100 aborts with no further trmt or done.
      resp_delay = 3;
      start_dump(0);
      found = 1'b0;
      for (int c = 0; c < max_cyc(); c++) begin
         @(negedge clk);
         if (trmt && int'(raddr) == 100) begin found = 1'b1; break; end
      end
      chk("r_reached_word100", int'(found), 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("r_outputs_zero", outs(), 0);
      mark();
      repeat (30) @(negedge clk);
      chk("r_no_trmt", byte_q.size() - b_byte, 0);
      chk("r_no_done", mon_done - b_done, 0);
      chk("r_no_ren", addr_q.size() - b_addr, 0);

      // Table of full dumps (first one is the clean restart at address 5).
      foreach (tv[i]) begin
         string tg;
         tg = $sformatf("vec%0d", i);
         resp_delay = tv[i].delay; stray = tv[i].stray;
         start_dump(tv[i].start);
         finish_wait(tg, tv[i].inject);
         repeat (2) @(negedge clk);
         chk({tg, " busy_after"}, int'(busy), 0);
         check_dump(tg, tv[i].start);
         nb = byte_q.size() - b_byte;
         chk({tg, " first_byte"}, (nb > 0) ? int'(byte_q[b_byte]) : -1, tv[i].first_b);
         chk({tg, " last_byte"}, (nb > 0) ? int'(byte_q[b_byte + nb - 1]) : -1, tv[i].last_b);
         chk({tg, " first_raddr"}, (addr_q.size() > b_addr) ? addr_q[b_addr] : -1, tv[i].start);
      end

      // Random contents, start, delay and stray tx_done; second dump requested
      // during FIN (ignored) and held into the following cycle (accepted).
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      s1 = int'($urandom % DEPTH);
      s2 = int'($urandom % DEPTH);
      resp_delay = int'($urandom_range(1, 3));
      stray = 1'b1;
      start_dump(s1);
      finish_wait("rnd0", 1'b0);
      dump = 1'b1; start_addr = ADDR_W'(s2);
      @(negedge clk);
      chk("b2b_fin_dump_ignored", int'(ren), 0);
      chk("b2b_busy_low", int'(busy), 0);
      check_dump("rnd0", s1);
      mark();
      @(negedge clk); dump = 1'b0;
      chk("b2b_ren", int'(ren), 1);
      chk("b2b_raddr", int'(raddr), s2);
      finish_wait("rnd1", 1'b0);
      repeat (2) @(negedge clk);
      chk("rnd1 busy_after", int'(busy), 0);
      check_dump("rnd1", s2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/smpl_ram_dump.md
Name: smpl_ram_dump

Overview:
- Read-side counterpart of the sample capture path: the capture path packs 4 samples per RAM word and pulses a write strobe; this block reads those words back out of the circular sample RAM.
- Starting at the oldest word, it unpacks each word into individual 8-bit samples and hands them one at a time to the UART transmitter.
- Sits between the capture RAM read port and the UART TX, and is started by the command processor after a capture completes.

Parameters:
- ADDR_W, 9, RAM address width.
- DEPTH, 384, number of RAM words in the circular buffer (must be ≤ 2^ADDR_W).
- SMPL_W, 8, bits per sample.
- SMPL_PER_WORD, 4, samples packed per RAM word; the first-captured sample is in the most-significant slot.

Ports:
- clk  in  1  100MHz system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- dump  in  1  one-cycle start pulse; ignored while busy.
- start_addr  in  ADDR_W  oldest word address (write pointer at capture end); must be < DEPTH.
- ren  out  1  RAM read enable.
- raddr  out  ADDR_W  RAM read address.
- rdata  in  SMPL_W*SMPL_PER_WORD  RAM read data, valid the cycle after ren.
- tx_data  out  SMPL_W  sample byte presented to the UART.
- trmt  out  1  one-cycle transmit request.
- tx_done  in  1  UART byte-complete pulse.
- busy  out  1  high from the cycle after dump until done.
- done  out  1  one-cycle pulse after the final byte's tx_done.

Behaviour:
- Reset: state IDLE; ren=0, raddr=0, tx_data=0, trmt=0, busy=0, done=0; word counter=0, slot index=0. Reset mid-dump aborts immediately, with no trmt or done afterwards.
- IDLE:
  - On dump=1, latch start_addr into raddr, clear the word count, busy←1, go to RD.
  - Other inputs are ignored.
- RD: ren=1 for exactly one cycle at raddr, then go to CAP.
- CAP:
  - Capture rdata into the word register, slot←0, go to SEND.
  - RAM read latency is exactly 1 cycle.
- SEND:
  - tx_data←word slot[slot], where slot 0 = bits [SMPL_W*SMPL_PER_WORD-1 -: SMPL_W].
  - trmt=1 for one cycle, then go to WAIT.
- WAIT: hold tx_data stable until tx_done. On tx_done:
  - If slot < SMPL_PER_WORD-1: slot++, go to SEND.
  - Else if word count == DEPTH-1: go to FIN.
  - Else: word count++, raddr ← (raddr == DEPTH-1) ? 0 : raddr+1, go to RD.
- FIN: done=1 for one cycle, busy←0, go to IDLE.
- Address wrap:
  - Wraps at DEPTH-1 → 0, not at 2^ADDR_W.
  - Exactly DEPTH words and DEPTH*SMPL_PER_WORD bytes are sent per dump, in address order start_addr, start_addr+1, … (mod DEPTH).
- tx_done in any state other than WAIT is ignored.
- A tx_done arriving in the same cycle trmt is asserted is not honoured; the next tx_done is required.
- dump while busy is ignored and does not restart.
- dump in the FIN cycle is ignored; dump in the cycle after FIN starts a new dump.
- Throughput: back-to-back bytes within a word are separated by 1 cycle (SEND) after tx_done. A new word costs 2 extra cycles (RD, CAP).
- ren is never asserted outside RD. raddr changes only on the IDLE→RD latch or the WAIT→RD advance.

Test Plan:
- Basic dump: RAM[i] = {i[7:0], i[7:0]+1, i[7:0]+2, i[7:0]+3}; start_addr=0; tx_done returned 5 cycles after each trmt → 1536 trmt pulses; first four tx_data are 00,01,02,03, last four are 7F,80,81,82 (word 383); one done pulse; busy low after.
- Wrap: start_addr=383 → raddr sequence 383, 0, 1, …, 382; total 384 ren pulses; no raddr ≥ 384 ever.
- Ignored start: dump pulsed while busy at word 10 → sequence unaffected, total still 1536 bytes; a dump issued 1 cycle after done begins a new dump (ren seen 2 cycles later).
- Stray tx_done: tx_done pulsed during RD/CAP/SEND → no slot or address advance; byte count unchanged.
- Reset mid-operation: rst_n=0 for 1 cycle during WAIT on word 100 → next cycle all outputs are 0, state IDLE, no done; a subsequent dump with start_addr=5 restarts cleanly at raddr=5.
- Timing: after dump, ren is asserted in cycle +1 and trmt in cycle +3; tx_data stays stable from trmt until tx_done even when tx_done is delayed 1000 cycles.
